pipelined_shifter: RTL and testbench

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shifter_level.sv | 32 +++
 rtl/pipelined_shifter.sv | 108 ++++++++++
 tb/tb_pipelined_shifter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and the
// per-stage record carried down the pipeline.
package shifter_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   // Stage record sized for the largest configuration; narrower instances use
   // the low bits of each field (tags wider than MAX_TAG_W are not supported).
   localparam int unsigned MAX_WIDTH = 64;
   localparam int unsigned MAX_SHW   = 6;
   localparam int unsigned MAX_TAG_W = 16;

   typedef struct packed {
      logic [MAX_WIDTH-1:0] data;
      logic [MAX_SHW-1:0]   amt;
      logic [1:0]           mode;
      logic                 sign;
      logic [MAX_TAG_W-1:0] tag;
   } stage_t;

endpackage

// File: rtl/shifter_level.sv
// One combinational barrel-shifter level: shifts by DIST when enabled,
// otherwise passes data through.
module shifter_level
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             enable_i,
   input  logic [1:0]       mode_i,
   input  logic             sign_i,
   output logic [WIDTH-1:0] data_c
);

   logic [WIDTH-1:0] fill_c;

   // SRA fills with the operand's original MSB, not the current level's MSB.
   always_comb begin
      fill_c = {WIDTH{sign_i}} << (WIDTH - DIST);
      data_c = data_i;
      if (enable_i) begin
         case (mode_i)
            MODE_SLL: data_c = data_i << DIST;
            MODE_SRL: data_c = data_i >> DIST;
            MODE_SRA: data_c = (data_i >> DIST) | fill_c;
            default:  data_c = (data_i << DIST) | (data_i >> (WIDTH - DIST));
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with a register after every
// LVL_PER_STG levels and a single global advance enable for backpressure.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter  int unsigned WIDTH       = 32,
   parameter  int unsigned LVL_PER_STG = 1,
   parameter  int unsigned TAG_W       = 4,
   localparam int unsigned SHW         = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] dataA,
   input  logic [SHW-1:0]   dataB,
   input  logic [1:0]       mode,
   input  logic [TAG_W-1:0] inTag,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] dataOut,
   output logic [TAG_W-1:0] outTag
);

   localparam int unsigned NSTG = SHW / LVL_PER_STG;

   logic                        adv_c;
   logic [NSTG-1:0]             vld_d;
   logic [NSTG-1:0]             vld_q;
   stage_t                      src_c [NSTG];
   stage_t                      st_d  [NSTG];
   stage_t                      st_q  [NSTG];
   logic [NSTG-1:0][WIDTH-1:0]  grp_out_c;
   logic                        unused_bits_c;

   assign adv_c   = !vld_q[NSTG-1] || outReady;
   assign inReady = adv_c;

   // Source record feeding each stage's group of levels.
   always_comb begin
      src_c[0]      = '0;
      src_c[0].data = MAX_WIDTH'(dataA);
      src_c[0].amt  = MAX_SHW'(dataB);
      src_c[0].mode = mode;
      src_c[0].sign = dataA[WIDTH-1];
      src_c[0].tag  = MAX_TAG_W'(inTag);
      vld_d[0]      = inValid;
      for (int g = 1; g < NSTG; g++) begin
         src_c[g] = st_q[g-1];
         vld_d[g] = vld_q[g-1];
      end
   end

   for (genvar k = 0; k < SHW; k++) begin : g_lvl
      localparam int unsigned GRP = k / LVL_PER_STG;
      logic [WIDTH-1:0] din_c;
      logic [WIDTH-1:0] dout_c;

      if (k % LVL_PER_STG == 0) begin : g_head
         assign din_c = WIDTH'(src_c[GRP].data);
      end else begin : g_chain
         assign din_c = g_lvl[k-1].dout_c;
      end

      shifter_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_level (
         .data_i   (din_c),
         .enable_i (src_c[GRP].amt[k]),
         .mode_i   (src_c[GRP].mode),
         .sign_i   (src_c[GRP].sign),
         .data_c   (dout_c)
      );
   end

   for (genvar g = 0; g < NSTG; g++) begin : g_grp
      assign grp_out_c[g] = g_lvl[(g + 1) * LVL_PER_STG - 1].dout_c;
   end

   always_comb begin
      for (int g = 0; g < NSTG; g++) begin
         st_d[g]      = src_c[g];
         st_d[g].data = MAX_WIDTH'(grp_out_c[g]);
      end
   end

   // Only valid bits and the output stage are reset; inner data may hold junk.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q        <= '0;
         st_q[NSTG-1] <= '0;
      end else if (adv_c) begin
         vld_q <= vld_d;
         for (int g = 0; g < NSTG; g++) begin
            st_q[g] <= st_d[g];
         end
      end
   end

   assign outValid = vld_q[NSTG-1];
   assign dataOut  = WIDTH'(st_q[NSTG-1].data);
   assign outTag   = TAG_W'(st_q[NSTG-1].tag);

   // Control fields and padding of the output record are not consumed.
   assign unused_bits_c = ^st_q[NSTG-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: directed vectors plus a randomized sweep over three
// configurations, checked against a queue-based arithmetic reference model.
module tb_pipelined_shifter;
   import shifter_pkg::*;

   localparam int unsigned M_NSTG = 5;

   typedef struct {
      int unsigned id;
      logic [63:0] data;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] data_a, data_out;
   logic [4:0]  data_b;
   logic [1:0]  op_mode;
   logic [3:0]  in_tag, out_tag;

   logic [1:0]  s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [63:0] s_a    [2];
   logic [5:0]  s_b    [2];
   logic [1:0]  s_mode [2];
   logic [3:0]  s_tag  [2];
   logic [7:0]  d8_out;
   logic [63:0] d64_out;
   logic [3:0]  t8_out, t64_out;

   int unsigned sw [2] = '{8, 64};

   exp_t        sq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          m_takes = 0;
   logic        m_acc;
   logic        m_saw_stall;
   logic [1:0]  s_acc;
   logic [31:0] m_exp;
   bit          m_lat_chk;

   pipelined_shifter u_dut (
      .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
      .dataA(data_a), .dataB(data_b), .mode(op_mode), .inTag(in_tag),
      .outValid(out_valid), .outReady(out_ready), .dataOut(data_out), .outTag(out_tag));

   pipelined_shifter #(.WIDTH(8), .LVL_PER_STG(3), .TAG_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .inValid(s_in_valid[0]), .inReady(s_in_ready[0]),
      .dataA(s_a[0][7:0]), .dataB(s_b[0][2:0]), .mode(s_mode[0]), .inTag(s_tag[0]),
      .outValid(s_out_valid[0]), .outReady(s_out_ready[0]), .dataOut(d8_out), .outTag(t8_out));

   pipelined_shifter #(.WIDTH(64), .LVL_PER_STG(2), .TAG_W(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .inValid(s_in_valid[1]), .inReady(s_in_ready[1]),
      .dataA(s_a[1]), .dataB(s_b[1]), .mode(s_mode[1]), .inTag(s_tag[1]),
      .outValid(s_out_valid[1]), .outReady(s_out_ready[1]), .dataOut(d64_out), .outTag(t64_out));

   // Reference: whole-word shift/rotate on a w-bit operand.
   function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input int unsigned b,
                                             input logic [1:0] md, input int unsigned w);
      logic [63:0] mask, a, r;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      a = a_in & mask;
      case (md)
         2'b00:   r = a << b;
         2'b01:   r = a >> b;
         2'b10:   begin
            r = a >> b;
            if (a[w-1]) r = r | ~(mask >> b);
         end
         default: r = (b == 0) ? a : ((a << b) | (a >> (w - b)));
      endcase
      return r & mask;
   endfunction

   function automatic int find_first(input int unsigned id);
      for (int i = 0; i < sq.size(); i++) if (sq[i].id == id) return i;
      return -1;
   endfunction

   function automatic int count_id(input int unsigned id);
      int n = 0;
      for (int i = 0; i < sq.size(); i++) if (sq[i].id == id) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   // Any valid output must be the oldest outstanding result for that DUT.
   task automatic observe(input int unsigned id, input logic v, input logic r,
                          input logic [63:0] d, input logic [3:0] t, input bit lat);
      int i;
      if (!v) return;
      i = find_first(id);
      if (i < 0) begin
         chk($sformatf("unexpected_valid_id%0d", id), 64'(v), 64'd0);
         return;
      end
      chk($sformatf("data_id%0d", id), d, sq[i].data);
      chk($sformatf("tag_id%0d", id), 64'(t), 64'(sq[i].tag));
      if (r) begin
         if (lat) chk("latency", 64'(cyc - sq[i].cyc), 64'(M_NSTG));
         if (id == 2) m_takes++;
         sq.delete(i);
      end
   endtask

   task automatic tick();
      exp_t e;
      #1;
      m_acc = in_valid && in_ready;
      if (!in_ready) m_saw_stall = 1'b1;
      if (m_acc) begin
         e = '{id: 2, data: 64'(m_exp), tag: in_tag, cyc: cyc};
         sq.push_back(e);
      end
      observe(2, out_valid, out_ready, 64'(data_out), out_tag, m_lat_chk);
      for (int i = 0; i < 2; i++) begin
         s_acc[i] = s_in_valid[i] && s_in_ready[i];
         if (s_acc[i]) begin
            e = '{id: i, data: ref_shift(s_a[i], 32'(s_b[i]), s_mode[i], sw[i]),
                  tag: s_tag[i], cyc: cyc};
            sq.push_back(e);
         end
      end
      observe(0, s_out_valid[0], s_out_ready[0], 64'(d8_out), t8_out, 1'b0);
      observe(1, s_out_valid[1], s_out_ready[1], d64_out, t64_out, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input logic [31:0] a, input logic [4:0] b, input logic [1:0] md,
                        input logic [3:0] t, input logic [31:0] e);
      in_valid = 1'b1; data_a = a; data_b = b; op_mode = md; in_tag = t; m_exp = e;
      out_ready = 1'b1;
      tick();
      chk("accept", 64'(m_acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      in_valid = 1'b0; s_in_valid = '0; out_ready = 1'b1; s_out_ready = '1;
      for (int n = 0; n < 64 && sq.size() != 0; n++) tick();
      chk(name, 64'(sq.size()), 64'd0);
   endtask

   logic [31:0] dv_a [11] = '{32'h80000001, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'hDEADBEEF, 32'h80000000, 32'hFFFFFFFF, 32'h00000001,
                              32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678};
   logic [4:0]  dv_b [11] = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31,
                              5'd16, 5'd8, 5'd4};
   logic [1:0]  dv_m [11] = '{MODE_ROL, MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_SRA,
                              MODE_SRL, MODE_ROL, MODE_SLL, MODE_SRA, MODE_ROL};
   logic [31:0] dv_e [11] = '{32'h00000003, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000001, 32'h80000000,
                              32'hFFFF0000, 32'h007FFFFF, 32'h23456781};

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  idx, base_takes;
      bit  new_op, m_hold;
      bit  s_hold [2];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_a = '0; data_b = '0;
      op_mode = '0; in_tag = '0; m_exp = '0; m_lat_chk = 1'b0; m_saw_stall = 1'b0;
      s_in_valid = '0; s_out_ready = '1;
      for (int i = 0; i < 2; i++) begin
         s_a[i] = '0; s_b[i] = '0; s_mode[i] = '0; s_tag[i] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outvalid", 64'(out_valid), 64'd0);
      chk("rst_dataout", 64'(data_out), 64'd0);
      chk("rst_outtag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_inready", 64'(in_ready), 64'd1);
      chk("rel_outvalid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;

      // Single SLL with latency check
      m_lat_chk = 1'b1;
      issue(32'h00000001, 5'd31, MODE_SLL, 4'd3, 32'h80000000);
      drain("drain_sll");

      // Back-to-back SRA then SRL
      issue(32'h80000000, 5'd4, MODE_SRA, 4'd1, 32'hF8000000);
      issue(32'h80000000, 5'd4, MODE_SRL, 4'd2, 32'h08000000);
      drain("drain_sra_srl");

      // Directed table, issued back-to-back
      for (int i = 0; i < 11; i++) issue(dv_a[i], dv_b[i], dv_m[i], 4'(i + 4), dv_e[i]);
      drain("drain_table");

      // Eight tagged ops with a consumer stall window
      m_lat_chk = 1'b0; m_saw_stall = 1'b0; idx = 0; new_op = 1'b1; base_takes = m_takes;
      for (int n = 0; n < 80; n++) begin
         out_ready = !(n >= 6 && n <= 10);
         if (idx < 8) begin
            if (new_op) begin
               data_a  = $urandom;
               data_b  = 5'($urandom_range(0, 31));
               op_mode = 2'($urandom_range(0, 3));
               in_tag  = 4'(idx);
               m_exp   = 32'(ref_shift(64'(data_a), 32'(data_b), op_mode, 32));
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         new_op = m_acc;
         if (m_acc) idx++;
         if (idx == 8 && count_id(2) == 0) break;
      end
      chk("stall_issued", 64'(idx), 64'd8);
      chk("stall_takes", 64'(m_takes - base_takes), 64'd8);
      chk("stall_inready_dropped", 64'(m_saw_stall), 64'd1);
      chk("stall_left", 64'(count_id(2)), 64'd0);

      // Reset with three ops in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) issue($urandom, 5'(i + 1), MODE_SLL, 4'(i), 32'h0);
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      sq.delete();
      rst_n = 1'b1;
      chk("flush_outvalid", 64'(out_valid), 64'd0);
      chk("flush_dataout", 64'(data_out), 64'd0);
      chk("flush_outtag", 64'(out_tag), 64'd0);
      chk("flush_inready", 64'(in_ready), 64'd1);
      repeat (8) tick();
      m_lat_chk = 1'b1;
      issue(32'h0000F00D, 5'd8, MODE_SLL, 4'd9, 32'h00F00D00);
      drain("drain_after_flush");

      // Random sweep on all three configurations
      m_lat_chk = 1'b0; m_hold = 1'b0; s_hold = '{1'b0, 1'b0};
      for (int n = 0; n < 600; n++) begin
         if (!m_hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            data_a   = ($urandom_range(0, 3) == 0) ? 32'h80000000 | $urandom : $urandom;
            data_b   = 5'($urandom_range(0, 31));
            op_mode  = 2'($urandom_range(0, 3));
            in_tag   = 4'($urandom_range(0, 15));
            m_exp    = 32'(ref_shift(64'(data_a), 32'(data_b), op_mode, 32));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (!s_hold[i]) begin
               s_in_valid[i] = ($urandom_range(0, 3) != 0);
               s_a[i]        = {$urandom, $urandom};
               s_b[i]        = 6'($urandom_range(0, sw[i] - 1));
               s_mode[i]     = 2'($urandom_range(0, 3));
               s_tag[i]      = 4'($urandom_range(0, 15));
            end
            s_out_ready[i] = ($urandom_range(0, 2) != 0);
         end
         tick();
         m_hold = in_valid && !m_acc;
         for (int i = 0; i < 2; i++) s_hold[i] = s_in_valid[i] && !s_acc[i];
      end
      drain("drain_random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
